// File: rtl/color_pkg.sv
// Shared definitions for the colour-reduction pipeline: default geometry,
// quantisation mode encodings and the keep-clamping helper.
package color_pkg;

    localparam int CW_DEF  = 8;
    localparam int NCH_DEF = 3;
    localparam int SBW_DEF = 3;
    localparam int KW      = 4;   // width of a keep value

    typedef enum logic [1:0] {
        MODE_TRUNC  = 2'd0,
        MODE_ROUND  = 2'd1,
        MODE_MID    = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    // A keep larger than the channel width means "keep everything".
    function automatic logic [KW-1:0] clamp_keep(input logic [KW-1:0] keep, input int cw);
        if (int'(keep) > cw) begin
            return KW'(cw);
        end
        return keep;
    endfunction

endpackage

// File: rtl/color_reduce_pipe_if.sv
// Pixel stream bundle: qualifier, start-of-frame, packed channels, sideband.
interface color_reduce_pipe_if
    import color_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int SBW = SBW_DEF
);
    logic               valid;
    logic               sof;
    logic [NCH*CW-1:0]  pixel;
    logic [SBW-1:0]     sb;

    modport master (output valid, sof, pixel, sb);
    modport slave  (input  valid, sof, pixel, sb);
endinterface

// File: rtl/color_reduce_pipe_chan_quant.sv
// One channel of the colour reducer. Stage 1 masks/adds at CW+1 bits so a
// rounding carry is kept; stage 2 saturates that carry or forces zero.
module chan_quant
    import color_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int SBW = SBW_DEF,
    parameter int CH  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    color_reduce_pipe_if.slave      in_if,
    input  logic [KW-1:0]           keep_i,
    input  mode_e                   mode_i,
    output logic [CW-1:0]           dout_o
);

    logic [KW-1:0] keep_eff;
    logic [KW-1:0] shift;
    logic [CW:0]   x_ext;
    logic [CW:0]   low_mask;
    logic [CW:0]   half;
    logic [CW:0]   sum_d;
    logic [CW-1:0] top_d;
    logic          zero_d;

    logic [CW:0]   sum_q;
    logic [CW-1:0] top_q;
    logic          zero_q;
    logic [CW-1:0] dout_q;

    // Stage-1 arithmetic: bucket mask, half-step, and the per-mode result.
    always_comb begin
        keep_eff = clamp_keep(keep_i, CW);
        shift    = KW'(CW) - keep_eff;
        x_ext    = {1'b0, in_if.pixel[(NCH-1-CH)*CW +: CW]};
        low_mask = ~({(CW+1){1'b1}} << shift);
        half     = low_mask ^ (low_mask >> 1);   // 2^(shift-1), or 0 when nothing is dropped
        top_d    = ~low_mask[CW-1:0];             // top bucket: kept bits all 1
        zero_d   = (keep_eff == '0) && (mode_i != MODE_BYPASS);
        sum_d    = x_ext;
        case (mode_i)
            MODE_TRUNC: sum_d = x_ext & ~low_mask;
            MODE_ROUND: sum_d = (x_ext + half) & ~low_mask;
            MODE_MID:   sum_d = (x_ext & ~low_mask) | half;
            default:    sum_d = x_ext;
        endcase
    end

    // Stage-1 registers; cleared for invalid pixels so idle output reads 0.
    always_ff @(posedge clk) begin
        if (reset || !in_if.valid) begin
            sum_q  <= '0;
            top_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            top_q  <= top_d;
            zero_q <= zero_d;
        end
    end

    // Stage-2 select: forced zero, saturated carry, or the stage-1 value.
    always_ff @(posedge clk) begin
        if (reset || zero_q) begin
            dout_q <= '0;
        end else if (sum_q[CW]) begin
            dout_q <= top_q;
        end else begin
            dout_q <= sum_q[CW-1:0];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/color_reduce_pipe.sv
// Two-stage colour reducer with shadowed per-channel configuration that
// becomes active on the first pixel of a frame.
module color_reduce_pipe
    import color_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int SBW = SBW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [NCH*CW-1:0]   in_pixel,
    input  logic [SBW-1:0]      in_sb,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_chan,
    input  logic [3:0]          cfg_keep,
    input  logic [1:0]          cfg_mode,
    output logic                out_valid,
    output logic                out_sof,
    output logic [NCH*CW-1:0]   out_pixel,
    output logic [SBW-1:0]      out_sb,
    output logic                cfg_pending
);

    color_reduce_pipe_if #(.NCH(NCH), .CW(CW), .SBW(SBW)) in_if ();

    assign in_if.valid = in_valid;
    assign in_if.sof   = in_sof;
    assign in_if.pixel = in_pixel;
    assign in_if.sb    = in_sb;

    logic  commit;
    logic  cfg_ok;
    mode_e mode_use;
    mode_e shadow_mode_q;
    mode_e active_mode_q;
    logic  pending_q;

    logic           valid_s1_q, valid_s2_q;
    logic           sof_s1_q,   sof_s2_q;
    logic [SBW-1:0] sb_s1_q,    sb_s2_q;

    // A valid SOF commits the shadow; that same pixel already sees it.
    assign commit   = in_valid && in_sof;
    assign cfg_ok   = cfg_we && (int'(cfg_chan) < NCH);
    assign mode_use = commit ? shadow_mode_q : active_mode_q;

    // Global mode shadow/active pair and the pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_mode_q <= MODE_TRUNC;
            active_mode_q <= MODE_TRUNC;
            pending_q     <= 1'b0;
        end else begin
            if (commit) begin
                active_mode_q <= shadow_mode_q;
            end
            if (cfg_ok) begin
                shadow_mode_q <= mode_e'(cfg_mode);
                pending_q     <= 1'b1;   // a write coincident with commit stays pending
            end else if (commit) begin
                pending_q     <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic [KW-1:0] shadow_keep_q;
            logic [KW-1:0] active_keep_q;
            logic [KW-1:0] keep_use;
            logic          wr_hit;

            assign wr_hit   = cfg_we && (cfg_chan == 2'(gi));
            assign keep_use = commit ? shadow_keep_q : active_keep_q;

            // Per-channel keep shadow/active pair; reset means identity.
            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_keep_q <= KW'(CW);
                    active_keep_q <= KW'(CW);
                end else begin
                    if (commit) begin
                        active_keep_q <= shadow_keep_q;
                    end
                    if (wr_hit) begin
                        shadow_keep_q <= cfg_keep;
                    end
                end
            end

            chan_quant #(.NCH(NCH), .CW(CW), .SBW(SBW), .CH(gi)) u_quant (
                .clk    (clk),
                .reset  (reset),
                .in_if  (in_if),
                .keep_i (keep_use),
                .mode_i (mode_use),
                .dout_o (out_pixel[(NCH-1-gi)*CW +: CW])
            );
        end
    endgenerate

    // Qualifier/sideband delay line matching the two quantiser stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_s1_q <= 1'b0;
            sof_s1_q   <= 1'b0;
            sb_s1_q    <= '0;
            valid_s2_q <= 1'b0;
            sof_s2_q   <= 1'b0;
            sb_s2_q    <= '0;
        end else begin
            valid_s1_q <= in_valid;
            sof_s1_q   <= in_valid && in_sof;
            sb_s1_q    <= in_valid ? in_sb : '0;
            valid_s2_q <= valid_s1_q;
            sof_s2_q   <= sof_s1_q;
            sb_s2_q    <= sb_s1_q;
        end
    end

    assign out_valid   = valid_s2_q;
    assign out_sof     = sof_s2_q;
    assign out_sb      = sb_s2_q;
    assign cfg_pending = pending_q;

endmodule
